alu_cond_unit: RTL and testbench
================================

ALU_COND_UNIT -- requirements
Module: alu_cond_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the result bus width; the bench uses WIDTH=4.
REQ-002 SHALL have clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have valid_i, input, 1, ALU result and flags are valid this cycle.
REQ-005 SHALL have ready_o, output, 1, the unit accepts the upstream beat this cycle.
REQ-006 SHALL have result_i, input, WIDTH, the ALU result (bus_o of alu).
REQ-007 SHALL have flag_n_i, flag_z_i, flag_c_i and flag_v_i, each input, 1, the ALU flags.
REQ-008 SHALL have cond_i, input, 4, the instruction condition field.
REQ-009 SHALL have set_flags_i, input, 1, the instruction requests an NZCV update.
REQ-010 SHALL have valid_o, output, 1, the output beat is valid.
REQ-011 SHALL have ready_i, input, 1, downstream accepts the output beat.
REQ-012 SHALL have result_o, output, WIDTH, the registered result.
REQ-013 SHALL have write_o, output, 1, the registered condition-passed (register write enable).
REQ-014 SHALL have nzcv_o, output, 4, the architectural status register {N,Z,C,V}, MSB = N.

Function
REQ-015 SHALL compute ready_o = !valid_o | ready_i combinationally; no combinational path from valid_i to ready_o.
REQ-016 SHALL accept a beat when valid_i & ready_o; on accept, capture result_i into result_o and the condition outcome into write_o, and set valid_o=1 on the next cycle (latency 1).
REQ-017 SHALL clear valid_o when ready_i=1 and no beat is accepted in the same cycle.
REQ-018 SHALL hold result_o, write_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-019 SHALL evaluate cond_i against the nzcv_o value held before the accepting edge: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
REQ-020 SHALL continue the evaluation: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 is treated as AL.
REQ-021 SHALL update nzcv_o with {flag_n_i,flag_z_i,flag_c_i,flag_v_i} on the accepting edge only when the condition passed and set_flags_i=1; otherwise nzcv_o holds.
REQ-022 SHALL pass a failed-condition beat downstream with write_o=0 and the result still captured; a failed beat does not modify nzcv_o.
REQ-023 SHALL evaluate back-to-back beats with the later beat seeing the NZCV written by the earlier beat; flags are not forwarded within a cycle.
REQ-024 SHALL ignore all inputs except ready_i when valid_i=0; nzcv_o does not change.
REQ-025 SHALL transfer the result unmodified, with no truncation or sign handling.

Reset
REQ-026 SHALL, while rst_i=1 at a clock edge, set valid_o=0, result_o=0, write_o=0 and nzcv_o=4'b0000, overriding any simultaneous accept.
REQ-027 SHALL, on reset mid-stall, discard the held beat; after reset, ready_o=1 and the first cond EQ evaluates false (Z=0).

Verification
REQ-028 SHALL cover (WIDTH=4): reset, then beat result=7, NZCV in 0000, cond=1110, S=1, ready_i=1 -> next cycle valid_o=1, result_o=7, write_o=1, nzcv_o=0000.
REQ-029 SHALL cover: beat result=0, Z=1, C=1, AL, S=1, then beat result=3, cond=0000 EQ, S=0 -> nzcv_o=0110 and the second beat write_o=1; then cond NE -> write_o=0 with nzcv_o unchanged.
REQ-030 SHALL cover: NZCV=1000, cond=1011 LT, S=1, new flags 0001 -> passes, nzcv_o=0001; next beat cond=1010 GE, S=1, flags 0100 -> fails, nzcv_o stays 0001.
REQ-031 SHALL cover: ready_i=0 for 3 cycles with valid_i held high and result=9 -> ready_o=0, result_o stable at the first value, nzcv_o updated once only; ready_i=1 -> the beat drains.
REQ-032 SHALL cover: rst_i=1 while valid_o=1 and stalled -> next cycle valid_o=0, result_o=0, write_o=0, nzcv_o=0000.
REQ-033 SHALL cover: continuous valid_i with ready_i=1 for 16 beats -> one output per cycle, no bubbles, order preserved.

Source files
------------

// File: rtl/alu_cond_unit_if.sv
// Bundles the ALU-result handshake into the condition unit and the registered output beat.
// Latency: none (wires only).
// Backpressure: ready_o / ready_i carry the valid-ready handshake on each side.
interface alu_cond_unit_if #(
   parameter int WIDTH = 32
);
   // Upstream side: ALU result, flags and instruction fields
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] result_i;
   logic             flag_n_i;
   logic             flag_z_i;
   logic             flag_c_i;
   logic             flag_v_i;
   logic [3:0]       cond_i;
   logic             set_flags_i;

   // Downstream side: registered beat and architectural status
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] result_o;
   logic             write_o;
   logic [3:0]       nzcv_o;

   // Environment view: drives the ALU beat and the downstream ready
   modport master (
      output valid_i, result_i, flag_n_i, flag_z_i, flag_c_i, flag_v_i,
             cond_i, set_flags_i, ready_i,
      input  ready_o, valid_o, result_o, write_o, nzcv_o
   );

   // Unit view: consumes the ALU beat, produces the registered beat
   modport slave (
      input  valid_i, result_i, flag_n_i, flag_z_i, flag_c_i, flag_v_i,
             cond_i, set_flags_i, ready_i,
      output ready_o, valid_o, result_o, write_o, nzcv_o
   );
endinterface

// File: rtl/alu_cond_unit.sv
// Evaluates the instruction condition against NZCV, registers result + write enable, updates NZCV.
// Latency: 1 cycle from accepted beat to valid_o.
// Backpressure: single output register; ready_o = !valid_o | ready_i, held stable while stalled.
module alu_cond_unit #(
   parameter int WIDTH = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   alu_cond_unit_if.slave bus
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             write;
   } beat_t;

   logic        valid_q;
   beat_t       beat_q;
   logic [3:0]  nzcv_q;

   logic        accept;
   logic        cond_pass;
   logic        n_flag;
   logic        z_flag;
   logic        c_flag;
   logic        v_flag;
   logic        flags_upd;
   logic [3:0]  nzcv_new;

   assign n_flag   = nzcv_q[3];
   assign z_flag   = nzcv_q[2];
   assign c_flag   = nzcv_q[1];
   assign v_flag   = nzcv_q[0];
   assign nzcv_new = {bus.flag_n_i, bus.flag_z_i, bus.flag_c_i, bus.flag_v_i};

   // Ready depends only on the output register and downstream ready, never on valid_i
   assign bus.ready_o = !valid_q | bus.ready_i;
   assign accept      = bus.valid_i & bus.ready_o;
   assign flags_upd   = accept & cond_pass & bus.set_flags_i;

   // Condition decode against the NZCV held before this edge (no same-cycle forwarding)
   always_comb begin
      cond_pass = 1'b1;
      case (bus.cond_i)
         4'b0000: cond_pass = z_flag;
         4'b0001: cond_pass = !z_flag;
         4'b0010: cond_pass = c_flag;
         4'b0011: cond_pass = !c_flag;
         4'b0100: cond_pass = n_flag;
         4'b0101: cond_pass = !n_flag;
         4'b0110: cond_pass = v_flag;
         4'b0111: cond_pass = !v_flag;
         4'b1000: cond_pass = c_flag & !z_flag;
         4'b1001: cond_pass = !c_flag | z_flag;
         4'b1010: cond_pass = (n_flag == v_flag);
         4'b1011: cond_pass = (n_flag != v_flag);
         4'b1100: cond_pass = !z_flag & (n_flag == v_flag);
         4'b1101: cond_pass = z_flag | (n_flag != v_flag);
         default: cond_pass = 1'b1;
      endcase
   end

   // Output beat register: load on accept, drop valid once drained, hold while stalled
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else if (accept) begin
         valid_q       <= 1'b1;
         beat_q.result <= bus.result_i;
         beat_q.write  <= cond_pass;
      end else if (bus.ready_i) begin
         valid_q <= 1'b0;
      end
   end

   // Status register: only a passing, flag-setting beat writes it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         nzcv_q <= 4'b0000;
      end else if (flags_upd) begin
         nzcv_q <= nzcv_new;
      end
   end

   assign bus.valid_o  = valid_q;
   assign bus.result_o = beat_q.result;
   assign bus.write_o  = beat_q.write;
   assign bus.nzcv_o   = nzcv_q;

endmodule

// File: tb/tb_alu_cond_unit.sv
// Self-checking bench for alu_cond_unit at WIDTH=4: directed scenarios plus randomized traffic.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values come from constants and a behavioural model of the condition table.
module tb_alu_cond_unit;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_cond_unit_if #(.WIDTH(W)) bus ();

   alu_cond_unit #(.WIDTH(W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   bit         m_valid;
   bit [W-1:0] m_result;
   bit         m_write;
   bit [3:0]   m_nzcv;

   // Condition table written as "base predicate per pair, odd code negates"
   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      if (c == 4'b1110 || c == 4'b1111) return 1'b1;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic drive(input bit v, input int res, input bit [3:0] flags,
                        input bit [3:0] cond, input bit s, input bit rdy);
      bus.valid_i     = v;
      bus.result_i    = res[W-1:0];
      {bus.flag_n_i, bus.flag_z_i, bus.flag_c_i, bus.flag_v_i} = flags;
      bus.cond_i      = cond;
      bus.set_flags_i = s;
      bus.ready_i     = rdy;
      #0;
   endtask

   // Advance the model by one edge using the inputs currently applied, then step the DUT
   task automatic tick();
      bit acc, ok;
      acc = bus.valid_i && (!m_valid || bus.ready_i);
      if (rst) begin
         m_valid = 0; m_result = '0; m_write = 0; m_nzcv = 4'b0000;
      end else if (acc) begin
         ok       = cond_ok(bus.cond_i, m_nzcv);
         m_valid  = 1;
         m_result = bus.result_i;
         m_write  = ok;
         if (ok && bus.set_flags_i)
            m_nzcv = {bus.flag_n_i, bus.flag_z_i, bus.flag_c_i, bus.flag_v_i};
      end else if (bus.ready_i) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1;
      drive(1, 5, 4'b1111, 4'b1110, 1, 1);
      tick(); tick();
      n_cmp++;
      if ({bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o} !== {1'b0, 4'd0, 1'b0, 4'b0000}) begin
         n_err++;
         $display("FAIL reset_state: got v=%b r=%h w=%b nzcv=%b, want 0/0/0/0000",
                  bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o);
      end
      rst = 0;
      drive(0, 0, 4'b0000, 4'b0000, 0, 1);
      n_cmp++;
      if (bus.ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b want 1", bus.ready_o);
      end
   endtask

   task automatic test_basic();
      drive(1, 7, 4'b0000, 4'b1110, 1, 1);
      tick();
      n_cmp++;
      if ({bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o} !== {1'b1, 4'd7, 1'b1, 4'b0000}) begin
         n_err++;
         $display("FAIL basic_al: got v=%b r=%h w=%b nzcv=%b, want 1/7/1/0000",
                  bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o);
      end
   endtask

   task automatic test_eq_ne();
      drive(1, 0, 4'b0110, 4'b1110, 1, 1);
      tick();
      n_cmp++;
      if ({bus.result_o, bus.write_o, bus.nzcv_o} !== {4'd0, 1'b1, 4'b0110}) begin
         n_err++;
         $display("FAIL flags_set: got r=%h w=%b nzcv=%b, want 0/1/0110", bus.result_o, bus.write_o, bus.nzcv_o);
      end
      drive(1, 3, 4'b0000, 4'b0000, 0, 1);
      tick();
      n_cmp++;
      if ({bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o} !== {1'b1, 4'd3, 1'b1, 4'b0110}) begin
         n_err++;
         $display("FAIL eq_pass: got v=%b r=%h w=%b nzcv=%b, want 1/3/1/0110",
                  bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o);
      end
      drive(1, 5, 4'b1111, 4'b0001, 1, 1);
      tick();
      n_cmp++;
      if ({bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o} !== {1'b1, 4'd5, 1'b0, 4'b0110}) begin
         n_err++;
         $display("FAIL ne_fail: got v=%b r=%h w=%b nzcv=%b, want 1/5/0/0110",
                  bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o);
      end
   endtask

   task automatic test_lt_ge();
      drive(1, 1, 4'b1000, 4'b1110, 1, 1);
      tick();
      drive(1, 2, 4'b0001, 4'b1011, 1, 1);
      tick();
      n_cmp++;
      if ({bus.result_o, bus.write_o, bus.nzcv_o} !== {4'd2, 1'b1, 4'b0001}) begin
         n_err++;
         $display("FAIL lt_pass: got r=%h w=%b nzcv=%b, want 2/1/0001", bus.result_o, bus.write_o, bus.nzcv_o);
      end
      drive(1, 4, 4'b0100, 4'b1010, 1, 1);
      tick();
      n_cmp++;
      if ({bus.result_o, bus.write_o, bus.nzcv_o} !== {4'd4, 1'b0, 4'b0001}) begin
         n_err++;
         $display("FAIL ge_fail: got r=%h w=%b nzcv=%b, want 4/0/0001", bus.result_o, bus.write_o, bus.nzcv_o);
      end
   endtask

   task automatic test_stall();
      drive(0, 0, 4'b0000, 4'b0000, 0, 1);
      tick();
      drive(1, 9, 4'b0101, 4'b1110, 1, 0);
      tick();
      n_cmp++;
      if ({bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o} !== {1'b1, 4'd9, 1'b1, 4'b0101}) begin
         n_err++;
         $display("FAIL stall_load: got v=%b r=%h w=%b nzcv=%b, want 1/9/1/0101",
                  bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o);
      end
      drive(1, 9, 4'b1010, 4'b1110, 1, 0);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (bus.ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.ready_o);
         end
         tick();
         n_cmp++;
         if ({bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o} !== {1'b1, 4'd9, 1'b1, 4'b0101}) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got v=%b r=%h w=%b nzcv=%b, want 1/9/1/0101",
                     i, bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o);
         end
      end
      drive(0, 9, 4'b1010, 4'b1110, 1, 1);
      n_cmp++;
      if (bus.ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL drain_ready: got %b want 1", bus.ready_o);
      end
      tick();
      n_cmp++;
      if ({bus.valid_o, bus.nzcv_o} !== {1'b0, 4'b0101}) begin
         n_err++;
         $display("FAIL drain: got v=%b nzcv=%b, want 0/0101", bus.valid_o, bus.nzcv_o);
      end
   endtask

   task automatic test_reset_stall();
      drive(1, 10, 4'b1100, 4'b1110, 1, 0);
      tick(); tick();
      rst = 1;
      tick();
      n_cmp++;
      if ({bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o} !== {1'b0, 4'd0, 1'b0, 4'b0000}) begin
         n_err++;
         $display("FAIL reset_stall: got v=%b r=%h w=%b nzcv=%b, want 0/0/0/0000",
                  bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o);
      end
      rst = 0;
      drive(1, 6, 4'b0000, 4'b0000, 0, 1);
      n_cmp++;
      if (bus.ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_ready: got %b want 1", bus.ready_o);
      end
      tick();
      n_cmp++;
      if ({bus.valid_o, bus.result_o, bus.write_o} !== {1'b1, 4'd6, 1'b0}) begin
         n_err++;
         $display("FAIL post_reset_eq: got v=%b r=%h w=%b, want 1/6/0", bus.valid_o, bus.result_o, bus.write_o);
      end
   endtask

   task automatic test_back_to_back();
      bit [W-1:0] exp_q[$];
      bit [W-1:0] want;
      for (int i = 0; i < 16; i++) begin
         drive(1, int'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 1'($urandom), 1);
         exp_q.push_back(bus.result_i);
         tick();
         want = exp_q.pop_front();
         n_cmp++;
         if ({bus.valid_o, bus.result_o} !== {1'b1, want}) begin
            n_err++;
            $display("FAIL b2b_order[%0d]: got v=%b r=%h, want 1/%h", i, bus.valid_o, bus.result_o, want);
         end
         n_cmp++;
         if ({bus.write_o, bus.nzcv_o} !== {m_write, m_nzcv}) begin
            n_err++;
            $display("FAIL b2b_cond[%0d]: got w=%b nzcv=%b, want %b/%b", i, bus.write_o, bus.nzcv_o, m_write, m_nzcv);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
               1'($urandom), ($urandom_range(0, 9) < 6));
         n_cmp++;
         if (bus.ready_o !== (!m_valid || bus.ready_i)) begin
            n_err++;
            $display("FAIL rnd_ready[%0d]: got %b want %b", i, bus.ready_o, (!m_valid || bus.ready_i));
         end
         tick();
         n_cmp++;
         if (bus.valid_o !== m_valid ||
             (m_valid && {bus.result_o, bus.write_o} !== {m_result, m_write}) ||
             bus.nzcv_o !== m_nzcv) begin
            n_err++;
            $display("FAIL rnd_state[%0d]: got v=%b r=%h w=%b nzcv=%b, want %b/%h/%b/%b", i,
                     bus.valid_o, bus.result_o, bus.write_o, bus.nzcv_o, m_valid, m_result, m_write, m_nzcv);
         end
      end
      rst = 0;
   endtask

   initial begin
      drive(0, 0, 4'b0000, 4'b0000, 0, 1);
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_eq_ne();
      test_lt_ge();
      test_stall();
      test_reset_stall();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
